// File: rtl/floo_inorder_rob.sv
// In-order response reorder buffer: slots are allocated in order, filled out of order, and drained in order.
// Optional feature: define FLOO_ROB_BYPASS_EN to forward a fill that targets the empty head slot in the same cycle.
module floo_inorder_rob #(
  parameter int unsigned NumSlots  = 8,
  parameter int unsigned DataWidth = 64
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        alloc_valid_i,
  output logic                        alloc_ready_o,
  output logic [$clog2(NumSlots)-1:0] alloc_idx_o,
  input  logic                        fill_valid_i,
  input  logic [$clog2(NumSlots)-1:0] fill_idx_i,
  input  logic [DataWidth-1:0]        fill_data_i,
  output logic                        out_valid_o,
  input  logic                        out_ready_i,
  output logic [DataWidth-1:0]        out_data_o,
  output logic                        err_o
);

  localparam int unsigned IdxW = $clog2(NumSlots);
  localparam int unsigned CntW = $clog2(NumSlots + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(NumSlots);

  logic [IdxW-1:0]      alloc_ptr_q, alloc_ptr_d;
  logic [IdxW-1:0]      head_ptr_q, head_ptr_d;
  logic [CntW-1:0]      count_q, count_d;
  logic [NumSlots-1:0]  busy_q, busy_d;
  logic [NumSlots-1:0]  full_q, full_d;
  logic                 err_q, err_d;
  logic [DataWidth-1:0] data_q [NumSlots];

  logic alloc_fire_s;
  logic fill_legal_s;
  logic drain_s;
  logic bypass_s;

  assign alloc_ready_o = (count_q != CntMax);
  assign alloc_idx_o   = alloc_ptr_q;
  assign err_o         = err_q;
  assign alloc_fire_s  = alloc_valid_i && alloc_ready_o;
  assign fill_legal_s  = fill_valid_i && busy_q[fill_idx_i] && !full_q[fill_idx_i];
  assign drain_s       = out_valid_o && out_ready_i;

`ifdef FLOO_ROB_BYPASS_EN
  // A legal fill of the head implies the head is busy and not yet full.
  assign bypass_s    = fill_legal_s && (fill_idx_i == head_ptr_q);
  assign out_valid_o = full_q[head_ptr_q] || bypass_s;
  assign out_data_o  = bypass_s ? fill_data_i : data_q[head_ptr_q];
`else
  assign bypass_s    = 1'b0;
  assign out_valid_o = full_q[head_ptr_q];
  assign out_data_o  = data_q[head_ptr_q];
`endif

  // Next-state for pointers, slot flags, occupancy and error pulse.
  always_comb begin
    alloc_ptr_d = alloc_ptr_q;
    head_ptr_d  = head_ptr_q;
    count_d     = count_q;
    busy_d      = busy_q;
    full_d      = full_q;
    err_d       = fill_valid_i && !fill_legal_s;

    if (alloc_fire_s) begin
      busy_d[alloc_ptr_q] = 1'b1;
      alloc_ptr_d         = alloc_ptr_q + IdxW'(1);
    end else begin
      alloc_ptr_d = alloc_ptr_q;
    end

    // A bypassed fill that drains immediately never marks the slot full.
    if (fill_legal_s && !(bypass_s && out_ready_i)) begin
      full_d[fill_idx_i] = 1'b1;
    end else begin
      full_d[fill_idx_i] = full_q[fill_idx_i];
    end

    if (drain_s) begin
      busy_d[head_ptr_q] = 1'b0;
      full_d[head_ptr_q] = 1'b0;
      head_ptr_d         = head_ptr_q + IdxW'(1);
    end else begin
      head_ptr_d = head_ptr_q;
    end

    case ({alloc_fire_s, drain_s})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state register with asynchronous reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      alloc_ptr_q <= '0;
      head_ptr_q  <= '0;
      count_q     <= '0;
      busy_q      <= '0;
      full_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      alloc_ptr_q <= alloc_ptr_d;
      head_ptr_q  <= head_ptr_d;
      count_q     <= count_d;
      busy_q      <= busy_d;
      full_q      <= full_d;
      err_q       <= err_d;
    end
  end

  // Payload storage; contents are not reset.
  always_ff @(posedge clk_i) begin
    if (fill_legal_s) begin
      data_q[fill_idx_i] <= fill_data_i;
    end
  end

endmodule
